// File: rtl/cmp_search_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmp_search_ctrl : MSB-first successive-approximation search of a 6-bit
// operand b, driving probe a into a comparator and consuming lt/ltu/eq.
// Revision: 1.0
// ---------------------------------------------------------------------------
module cmp_search_ctrl #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic         lt,
  input  logic         ltu,
  input  logic         eq,
  output logic [W-1:0] a,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [2:0]   steps,
  output logic         err
);

  localparam int KW = $clog2(W);
  localparam logic [W-1:0] C_MSB = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0] C_KTOP = KW'(W-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          signed_q, signed_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  trial_q, trial_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  result_q, result_d;
  logic [2:0]    steps_q, steps_d;
  logic          err_q, err_d;

  logic [W-1:0]  mask_w;
  logic          flag_w;
  logic [W-1:0]  bit_k_w;
  logic [W-1:0]  base_w;
  logic [W-1:0]  next_trial_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      signed_q <= 1'b0;
      k_q      <= '0;
      trial_q  <= '0;
      a_q      <= '0;
      result_q <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      k_q      <= k_d;
      trial_q  <= trial_d;
      a_q      <= a_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
    end
  end

  // Search runs in an offset domain (MSB flipped in signed mode) so that a
  // single unsigned bisection covers both orderings.
  always_comb begin
    mask_w       = signed_q ? C_MSB : '0;
    flag_w       = signed_q ? lt : ltu;
    bit_k_w      = C_ONE << k_q;
    base_w       = flag_w ? trial_q : (trial_q & ~bit_k_w);
    next_trial_w = base_w | (bit_k_w >> 1);
  end

  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    k_d      = k_q;
    trial_d  = trial_q;
    a_d      = a_q;
    result_d = result_q;
    steps_d  = steps_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          signed_d = is_signed;
          k_d      = C_KTOP;
          trial_d  = C_MSB;
          steps_d  = '0;
          err_d    = 1'b0;
          a_d      = C_MSB ^ (is_signed ? C_MSB : '0);
          state_d  = PROBE;
        end
      end
      PROBE: begin
        steps_d = steps_q + 3'd1;
        if (eq && flag_w) begin
          err_d = 1'b1;
        end
        if (eq) begin
          result_d = trial_q ^ mask_w;
          state_d  = DONE;
        end else if (k_q == '0) begin
          result_d = base_w ^ mask_w;
          state_d  = DONE;
        end else begin
          k_d     = k_q - 1'b1;
          trial_d = next_trial_w;
          a_d     = next_trial_w ^ mask_w;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign a      = a_q;
  assign busy   = (state_q == PROBE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign steps  = steps_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_search_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmp_search_ctrl : bench with a behavioural comparator and a reference
// model of the search, directed cases plus randomized operands.
// ---------------------------------------------------------------------------
module tb_cmp_search_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       is_signed;
  logic       lt;
  logic       ltu;
  logic       eq;
  logic [5:0] a;
  logic       busy;
  logic       done;
  logic [5:0] result;
  logic [2:0] steps;
  logic       err;

  logic [5:0] b_val;
  logic       force_bad;
  int         n_checks;
  int         n_errors;

  cmp_search_ctrl #(.W(6)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .lt        (lt),
    .ltu       (ltu),
    .eq        (eq),
    .a         (a),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .steps     (steps),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational comparator on the other side of the probe.
  always_comb begin
    lt  = ($signed(a) < $signed(b_val));
    ltu = (a < b_val);
    eq  = (a == b_val);
    if (force_bad) begin
      eq  = 1'b1;
      ltu = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Probe i (0-based) in the offset domain: top i bits of the target, then a 1.
  function automatic int probe_off(input int t, input int i);
    int hi;
    hi = (t >> (6 - i)) << (6 - i);
    return hi | (1 << (5 - i));
  endfunction

  function automatic int model_steps(input int t);
    for (int i = 0; i < 6; i++) begin
      if (probe_off(t, i) == t) return i + 1;
    end
    return 6;
  endfunction

  // mode 0: plain; 1: start re-pulsed during a probe; 2: start held in DONE.
  task automatic run_search(input logic [5:0] bv, input logic sgn, input int mode);
    int t;
    int n;
    int msk;
    msk = sgn ? 32 : 0;
    t   = int'(bv) ^ msk;
    n   = model_steps(t);
    b_val     = bv;
    is_signed = sgn;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    is_signed = ~sgn;
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("probe_a[%0d] b=%0h s=%0b", i, bv, sgn), 32'(a), 32'(probe_off(t, i) ^ msk));
      check_eq("busy_in_probe", 32'(busy), 32'd1);
      check_eq("done_in_probe", 32'(done), 32'd0);
      start = (mode == 1 && i < 2) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_eq($sformatf("done b=%0h", bv), 32'(done), 32'd1);
    check_eq("busy_in_done", 32'(busy), 32'd0);
    check_eq($sformatf("result b=%0h s=%0b", bv, sgn), 32'(result), 32'(bv));
    check_eq($sformatf("steps b=%0h s=%0b", bv, sgn), 32'(steps), 32'(n));
    check_eq("err_clean", 32'(err), 32'd0);
    if (mode == 2) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("done_pulse_end", 32'(done), 32'd0);
    check_eq("idle_not_busy", 32'(busy), 32'd0);
    check_eq("result_hold", 32'(result), 32'(bv));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    b_val     = '0;
    force_bad = 1'b0;
    #12;
    check_eq("rst_a", 32'(a), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_steps", 32'(steps), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_search(6'd0,  1'b0, 0);
    run_search(6'd32, 1'b0, 0);
    run_search(6'd63, 1'b0, 0);
    run_search(6'h20, 1'b1, 0);
    run_search(6'd0,  1'b1, 0);
    run_search(6'd63, 1'b0, 1);
    run_search(6'd17, 1'b1, 2);

    // Reset during the third probe aborts with no done.
    @(posedge clk); #1;
    b_val = 6'h2A; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_a", 32'(a), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_result", 32'(result), 32'd0);
    check_eq("mid_rst_steps", 32'(steps), 32'd0);
    @(posedge clk); #1;
    check_eq("mid_rst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    run_search(6'd5, 1'b0, 0);

    // Contradictory flags: eq with ltu in unsigned mode.
    @(posedge clk); #1;
    force_bad = 1'b1; b_val = 6'd9; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("bad_probe_a", 32'(a), 32'd32);
    @(posedge clk); #1;
    check_eq("bad_done", 32'(done), 32'd1);
    check_eq("bad_err", 32'(err), 32'd1);
    check_eq("bad_steps", 32'(steps), 32'd1);
    check_eq("bad_result", 32'(result), 32'd32);
    force_bad = 1'b0;
    @(posedge clk); #1;
    check_eq("bad_err_hold", 32'(err), 32'd1);
    run_search(6'd40, 1'b0, 0);

    for (int r = 0; r < 40; r++) begin
      run_search(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmp_search_ctrl.md
Name: cmp_search_ctrl

Overview:
- Sequential initiator that drives operand `a` into the team's 6-bit comparator block (outputs lt, ltu, eq) and consumes its flags.
- Recovers an unknown 6-bit operand `b`, held on the comparator's other input, by MSB-first successive approximation, with early exit on equality.
- Supports signed (two's complement) and unsigned search; used to exercise the comparator from the other side.

Parameters:
- W, 6, operand width; only W=6 is verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a search; sampled in IDLE only
- is_signed  input  1  search mode, latched when start is accepted; 1 = use lt, 0 = use ltu
- lt  input  1  comparator flag: signed a < b (combinational, same cycle)
- ltu  input  1  comparator flag: unsigned a < b
- eq  input  1  comparator flag: a == b
- a  output  W  probe operand driven to the comparator (registered)
- busy  output  1  high while in PROBE
- done  output  1  one-cycle pulse when result is valid
- result  output  W  recovered b; holds until next accepted start
- steps  output  3  number of probes used in the last search (1..6)
- err  output  1  protocol error: eq high together with the active lt flag during any probe of the last search

Behaviour:
- Reset (async, rst_n=0): state=IDLE; a=0, busy=0, done=0, result=0, steps=0, err=0; all internal registers cleared. Reset mid-search aborts it immediately and emits no done.
- Internal offset domain: mask = 6'h20 if signed, else 0. Output a = trial ^ mask. This maps signed order onto unsigned order.
- States: IDLE, PROBE, DONE.
- IDLE: on start=1:
  - latch is_signed;
  - k=5, trial=6'b100000, steps=0, err=0;
  - go to PROBE.
  - a is updated on the same edge, so a valid probe is present for the whole first PROBE cycle.
- PROBE (one probe per cycle; f = is_signed ? lt : ltu):
  - steps increments each PROBE cycle.
  - If eq and f: set err; treat the probe as eq.
  - If eq: result = trial ^ mask; go to DONE.
  - Else if f (probe < b): base = trial. Else: base = trial with bit k cleared.
  - If k==0: result = base ^ mask; go to DONE.
  - Else: k = k-1; trial = base | (1 << (k-1)); a updates on the same edge.
- DONE: done=1 for exactly this one cycle, busy=0; then go to IDLE. result, steps and err hold until the next accepted start.
- Latency:
  - start accepted at edge 0; probes occupy cycles 1..N with N ≤ 6; done is high in cycle N+1.
  - Worst case: done 7 cycles after start.
- start while busy or in DONE: ignored, with no effect on the search in progress.
- is_signed changes mid-search: ignored (latched copy used).
- a in IDLE/DONE: holds its last probe value; not meaningful.
- Flags are sampled only in PROBE and must settle within the cycle (comparator is combinational).

Test Plan:
- Unsigned, b=0, start pulse:
  - a sequence 32,16,8,4,2,1 over 6 cycles;
  - done 7 cycles after start; result=0, steps=6, err=0.
- Unsigned, b=32:
  - first probe a=32 hits eq;
  - done 2 cycles after start; result=32, steps=1.
- Unsigned, b=63:
  - probes 32,48,56,60,62,63; eq on the 6th probe;
  - result=63, steps=6.
- Signed, b=6'h20 (-32):
  - probes a=0x00,0x30,0x28,0x24,0x22,0x21; none equal;
  - result=0x20, steps=6.
- Signed, b=0:
  - first probe a=0 gives eq; result=0, steps=1.
- Reset during the 3rd probe, then restart with b=5 unsigned:
  - all outputs 0 immediately with no done;
  - new search returns result=5.
- Also: start re-asserted while busy is ignored (same result and steps as an uninterrupted search).
- Also: comparator model forced to eq=1 and ltu=1 in unsigned mode gives err=1 and steps=1.
